serial_pattern_det: RTL and testbench

Serial bit-stream pattern detector that sits directly downstream of the D flip-flop stage (`D`). It samples the flip-flop's complementary outputs `q` and `q_` as a serial data stream on strobe cycles. It checks that the two rails are complementary, shifts valid bits into a history register and flags every occurrence of a configurable bit pattern. A saturating hit counter and a rail-error pulse are exposed for display or for the next lab stage.

---
 rtl/serial_pattern_det_if.sv | 33 +++
 rtl/serial_pattern_det.sv | 118 +++++++++++
 tb/tb_serial_pattern_det.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_det_if.sv
// Bit-stream bundle between the flip-flop stage and the pattern detector.
// The master side drives the strobe and both flip-flop rails. The slave side
// (the detector) returns the history, the pulses, the hit counter and its
// FILL/ARMED state.
//
// Handshake: din_valid is a one-cycle strobe with no back-pressure. din and
// din_n are meaningful only in a cycle where din_valid is high. Every strobe
// is consumed on the rising edge that samples it, so strobes may arrive on
// consecutive clocks.
interface serial_pattern_det_if #(
  parameter int PATTERN_W = 4,
  parameter int CNT_W     = 8
);
  logic                 din_valid;
  logic                 din;
  logic                 din_n;
  logic [PATTERN_W-1:0] hist;
  logic                 hit;
  logic                 rail_err;
  logic [CNT_W-1:0]     hit_cnt;
  logic                 cnt_sat;
  logic                 armed;

  modport master (
    output din_valid, din, din_n,
    input  hist, hit, rail_err, hit_cnt, cnt_sat, armed
  );

  modport slave (
    input  din_valid, din, din_n,
    output hist, hit, rail_err, hit_cnt, cnt_sat, armed
  );
endinterface

// File: rtl/serial_pattern_det.sv
// Serial pattern detector fed by the complementary outputs of a D flip-flop.
// Each strobe is rail-checked (din must differ from din_n). Good bits shift
// into a history register, newest bit in the LSB. A match of PATTERN (MSB =
// oldest bit) once the history is completely filled produces a one-cycle hit
// pulse and bumps a saturating hit counter.
//
// Optional feature macro: DET_OVERLAP_EN
//   defined   - overlapping detection: after a match the history stays armed,
//               so the tail of one match can start the next one.
//   undefined - non-overlapping detection: a match empties the fill count,
//               so PATTERN_W fresh good bits are needed before the next hit.
//
// The connected interface instance must use the same PATTERN_W and CNT_W as
// this module.
module serial_pattern_det #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter int                   CNT_W     = 8
) (
  input  logic                clk,
  input  logic                clr,
  serial_pattern_det_if.slave bus
);

  // fill counts 0..PATTERN_W inclusive, so it needs one more code than the
  // pattern length.
  localparam int                FILL_W = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FULL   = FILL_W'(PATTERN_W);

  // FILL: still collecting the first PATTERN_W good bits.
  // ARMED: history completely filled, so every good bit can complete a match.
  typedef enum logic {
    FILL_ST  = 1'b0,
    ARMED_ST = 1'b1
  } state_t;

  state_t               state;
  logic [FILL_W-1:0]    fill;
  logic [PATTERN_W-1:0] hist_q;
  logic                 hit_q;
  logic                 rail_q;
  logic [CNT_W-1:0]     hit_cnt_q;
  logic                 cnt_sat_q;

  logic                 bit_ok;
  logic                 bit_bad;
  logic [PATTERN_W-1:0] hist_nxt;
  logic [FILL_W-1:0]    fill_inc;
  logic                 match;
  logic [CNT_W-1:0]     cnt_nxt;

  // Qualify the strobe and compute the post-shift, post-increment view that
  // the match decision is based on.
  always_comb begin
    bit_ok   = bus.din_valid && (bus.din != bus.din_n);
    bit_bad  = bus.din_valid && (bus.din == bus.din_n);
    hist_nxt = {hist_q[PATTERN_W-2:0], bus.din};
    fill_inc = (fill < FULL) ? fill + 1'b1 : fill;
    match    = bit_ok && (hist_nxt == PATTERN) && (fill_inc == FULL);
    cnt_nxt  = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + 1'b1;
  end

  // Fill-state FSM with the history, pulses and counter, all registered.
  // clr wins over a strobe in the same cycle, so that bit is discarded.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= FILL_ST;
      fill      <= '0;
      hist_q    <= '0;
      hit_q     <= 1'b0;
      rail_q    <= 1'b0;
      hit_cnt_q <= '0;
      cnt_sat_q <= 1'b0;
    end else begin
      // Pulses default low so each one lasts a single clock, even when
      // strobes arrive back to back.
      hit_q  <= 1'b0;
      rail_q <= 1'b0;

      // A bad strobe only raises the error pulse. History, fill and counter
      // are left as they were.
      if (bit_bad) begin
        rail_q <= 1'b1;
      end

      if (bit_ok) begin
        hist_q <= hist_nxt;
        if (match) begin
          hit_q     <= 1'b1;
          hit_cnt_q <= cnt_nxt;
          // Registered together with the counter so it rises with the hit
          // that fills the counter.
          cnt_sat_q <= &cnt_nxt;
`ifdef DET_OVERLAP_EN
          fill      <= fill_inc;
          state     <= ARMED_ST;
`else
          // The history still shows the shifted value. Only the fill count
          // restarts, so the matched bits cannot be reused.
          fill      <= '0;
          state     <= FILL_ST;
`endif
        end else begin
          fill  <= fill_inc;
          state <= (fill_inc == FULL) ? ARMED_ST : FILL_ST;
        end
      end
    end
  end

  assign bus.hist     = hist_q;
  assign bus.hit      = hit_q;
  assign bus.rail_err = rail_q;
  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.cnt_sat  = cnt_sat_q;
  assign bus.armed    = (state == ARMED_ST);

endmodule

// File: tb/tb_serial_pattern_det.sv
// Bench for serial_pattern_det. Instance dut_a uses the default 8-bit counter.
// Instance dut_s uses a 2-bit counter so that saturation can be reached.
// Drivers push one hand-computed response per issued strobe. Per-instance
// monitors pop and compare in the cycle after each strobe, and check that
// the pulses are low in every other cycle.
module tb_serial_pattern_det;

  logic clk = 1'b0;
  logic clr = 1'b1;

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  serial_pattern_det_if #(.PATTERN_W(4), .CNT_W(8)) ifa ();
  serial_pattern_det_if #(.PATTERN_W(4), .CNT_W(2)) ifs ();

  serial_pattern_det #(.PATTERN_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
    .clk (clk),
    .clr (clr),
    .bus (ifa)
  );

  serial_pattern_det #(.PATTERN_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut_s (
    .clk (clk),
    .clr (clr),
    .bus (ifs)
  );

  int total = 0;
  int bad   = 0;

  // Response word: {hit, rail_err, cnt_sat, hit_cnt[7:0], hist[3:0]}.
  logic [14:0] exp_a_q[$];
  logic [14:0] exp_s_q[$];

  logic strobe_a_d = 1'b0;
  logic strobe_s_d = 1'b0;

  function automatic logic [14:0] act_a();
    return {ifa.hit, ifa.rail_err, ifa.cnt_sat, ifa.hit_cnt, ifa.hist};
  endfunction

  function automatic logic [14:0] act_s();
    return {ifs.hit, ifs.rail_err, ifs.cnt_sat, 6'd0, ifs.hit_cnt, ifs.hist};
  endfunction

  task automatic compare(input string name, input logic [14:0] act, input logic [14:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got hit=%b rail=%b sat=%b cnt=%0d hist=%b, want hit=%b rail=%b sat=%b cnt=%0d hist=%b",
               name, act[14], act[13], act[12], act[11:4], act[3:0],
               exp[14], exp[13], exp[12], exp[11:4], exp[3:0]);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic check_empty(input string name, input int size);
    total = total + 1;
    if (size != 0) begin
      bad = bad + 1;
      $display("FAIL %s: %0d responses outstanding, want 0", name, size);
    end
  endtask

  // Remember which edges sampled a strobe that clr did not override.
  always @(posedge clk) begin
    strobe_a_d <= ifa.din_valid && !clr;
    strobe_s_d <= ifs.din_valid && !clr;
  end

  // Monitor for dut_a.
  always @(negedge clk) begin
    if (strobe_a_d) begin
      if (exp_a_q.size() == 0) begin
        check_empty("a_unexpected_strobe", 1);
      end else begin
        compare("a_strobe", act_a(), exp_a_q.pop_front());
      end
    end else begin
      compare("a_idle_pulses", {ifa.hit, ifa.rail_err, 13'd0}, 15'd0);
    end
  end

  // Monitor for dut_s.
  always @(negedge clk) begin
    if (strobe_s_d) begin
      if (exp_s_q.size() == 0) begin
        check_empty("s_unexpected_strobe", 1);
      end else begin
        compare("s_strobe", act_s(), exp_s_q.pop_front());
      end
    end else begin
      compare("s_idle_pulses", {ifs.hit, ifs.rail_err, 13'd0}, 15'd0);
    end
  end

  task automatic send_a(input logic d, input logic dn, input logic e_hit, input logic e_rail,
                        input logic [7:0] e_cnt, input logic [3:0] e_hist);
    @(negedge clk);
    ifa.din_valid = 1'b1;
    ifa.din       = d;
    ifa.din_n     = dn;
    exp_a_q.push_back({e_hit, e_rail, 1'b0, e_cnt, e_hist});
  endtask

  task automatic send_s(input logic d, input logic e_hit, input logic e_sat,
                        input logic [1:0] e_cnt, input logic [3:0] e_hist);
    @(negedge clk);
    ifs.din_valid = 1'b1;
    ifs.din       = d;
    ifs.din_n     = ~d;
    exp_s_q.push_back({e_hit, 1'b0, e_sat, 6'd0, e_cnt, e_hist});
  endtask

  task automatic idle();
    @(negedge clk);
    ifa.din_valid = 1'b0;
    ifs.din_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    ifa.din_valid = 1'b0;
    ifs.din_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    ifa.din_valid = 1'b0;
    ifa.din       = 1'b0;
    ifa.din_n     = 1'b1;
    ifs.din_valid = 1'b0;
    ifs.din       = 1'b0;
    ifs.din_n     = 1'b1;

    // Reset held for two cycles while strobing good 1 bits.
    @(negedge clk);
    clr = 1'b1;
    ifa.din_valid = 1'b1;
    ifa.din       = 1'b1;
    ifa.din_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    compare("reset_state_a", act_a(), 15'd0);
    compare("reset_state_s", act_s(), 15'd0);
    check_bit("reset_armed_a", ifa.armed, 1'b0);
    check_bit("reset_armed_s", ifs.armed, 1'b0);
    clr = 1'b0;
    ifa.din_valid = 1'b0;
    send_a(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0001);
    send_a(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0011);
    send_a(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0111);
    idle();
    @(negedge clk);
    check_bit("three_bits_not_armed", ifa.armed, 1'b0);
    pulse_clr();

    // Stream 1,0,1,1,0,1,1 on consecutive strobes.
    send_a(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0001);
    send_a(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0010);
    send_a(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0101);
    send_a(1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 4'b1011);
    send_a(1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 4'b0110);
    send_a(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 4'b1101);
`ifdef DET_OVERLAP_EN
    send_a(1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 4'b1011);
`else
    send_a(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 4'b1011);
`endif
    idle();
    pulse_clr();

    // Rail errors: 1,0,[1/1],1,1 then [0/0] and one more good 1.
    send_a(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0001);
    send_a(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0010);
    send_a(1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 4'b0010);
    send_a(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0101);
    send_a(1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 4'b1011);
    send_a(1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 4'b1011);
    send_a(1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0111);
    idle();
    pulse_clr();

    // Reset mid-pattern: 1,0,1 then clr together with a strobe of 1.
    send_a(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0001);
    send_a(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0010);
    send_a(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0101);
    @(negedge clk);
    clr       = 1'b1;
    ifa.din   = 1'b1;
    ifa.din_n = 1'b0;
    @(negedge clk);
    compare("mid_reset_state", act_a(), 15'd0);
    clr = 1'b0;
    ifa.din_valid = 1'b0;
    // Next 1,0,1,1 with idle gaps between the first bits.
    send_a(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0001);
    idle();
    send_a(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 4'b0010);
    idle();
    send_a(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'b0101);
    send_a(1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 4'b1011);
    idle();
    @(negedge clk);
`ifdef DET_OVERLAP_EN
    check_bit("armed_after_hit", ifa.armed, 1'b1);
`else
    check_bit("armed_after_hit", ifa.armed, 1'b0);
`endif

    // Saturation on the 2-bit counter instance.
    send_s(1'b1, 1'b0, 1'b0, 2'd0, 4'b0001);
    send_s(1'b0, 1'b0, 1'b0, 2'd0, 4'b0010);
    send_s(1'b1, 1'b0, 1'b0, 2'd0, 4'b0101);
    send_s(1'b1, 1'b1, 1'b0, 2'd1, 4'b1011);
`ifdef DET_OVERLAP_EN
    send_s(1'b0, 1'b0, 1'b0, 2'd1, 4'b0110);
    send_s(1'b1, 1'b0, 1'b0, 2'd1, 4'b1101);
    send_s(1'b1, 1'b1, 1'b0, 2'd2, 4'b1011);
    send_s(1'b0, 1'b0, 1'b0, 2'd2, 4'b0110);
    send_s(1'b1, 1'b0, 1'b0, 2'd2, 4'b1101);
    send_s(1'b1, 1'b1, 1'b1, 2'd3, 4'b1011);
    send_s(1'b0, 1'b0, 1'b1, 2'd3, 4'b0110);
    send_s(1'b1, 1'b0, 1'b1, 2'd3, 4'b1101);
    send_s(1'b1, 1'b1, 1'b1, 2'd3, 4'b1011);
`else
    send_s(1'b1, 1'b0, 1'b0, 2'd1, 4'b0111);
    send_s(1'b0, 1'b0, 1'b0, 2'd1, 4'b1110);
    send_s(1'b1, 1'b0, 1'b0, 2'd1, 4'b1101);
    send_s(1'b1, 1'b1, 1'b0, 2'd2, 4'b1011);
    send_s(1'b1, 1'b0, 1'b0, 2'd2, 4'b0111);
    send_s(1'b0, 1'b0, 1'b0, 2'd2, 4'b1110);
    send_s(1'b1, 1'b0, 1'b0, 2'd2, 4'b1101);
    send_s(1'b1, 1'b1, 1'b1, 2'd3, 4'b1011);
    send_s(1'b1, 1'b0, 1'b1, 2'd3, 4'b0111);
    send_s(1'b0, 1'b0, 1'b1, 2'd3, 4'b1110);
    send_s(1'b1, 1'b0, 1'b1, 2'd3, 4'b1101);
    send_s(1'b1, 1'b1, 1'b1, 2'd3, 4'b1011);
`endif
    idle();
    @(negedge clk);
    @(negedge clk);
    check_empty("a_responses_drained", exp_a_q.size());
    check_empty("s_responses_drained", exp_s_q.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end

endmodule
